// File: rtl/imem_loader_if.sv
// imem_loader_if: program-load word stream into the instruction memory.
//   load_valid - a load word is present (master -> slave)
//   load_ready - slave accepts a word this cycle (slave -> master)
//   load_data  - load word, IW bits (master -> slave)
//   load_last  - marks the final program word (master -> slave)
interface imem_loader_if #(
  parameter int IW = 12
);
  logic          load_valid;
  logic          load_ready;
  logic [IW-1:0] load_data;
  logic          load_last;

  modport master (output load_valid, load_data, load_last, input load_ready);
  modport slave  (input load_valid, load_data, load_last, output load_ready);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: 2^P-word instruction store with a program-load front end.
// A program arrives over the load stream, the unused tail is filled with
// FILL, then the control FSM is released from reset and served with a
// one-cycle registered fetch.
//
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN
//   defined   - one extra word after the program is an XOR checksum; a
//               mismatch parks the block in ERROR with load_error set.
//   undefined - no checksum word, load_error tied 0.
//
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   load                - load word stream (slave side of imem_loader_if)
//   reload              - restart loading (honoured in RUN/ERROR only)
//   cpu_rst_n           - active-low reset to the FSM/datapath, high in RUN
//   loaded              - high while in RUN
//   load_error          - checksum failure
//   word_count          - number of program words written (P+1 bits)
//   en_read_instr       - fetch strobe
//   read_address_instr  - fetch address
//   instruction_out     - fetched instruction, 0 outside RUN
module imem_loader #(
  parameter int M = 4,
  parameter int P = 6,
  localparam int IW = 4 + 2 * M,
  parameter logic [IW-1:0] FILL = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  imem_loader_if.slave    load,
  input  logic            reload,
  output logic            cpu_rst_n,
  output logic            loaded,
  output logic            load_error,
  output logic [P:0]      word_count,
  input  logic            en_read_instr,
  input  logic [P-1:0]    read_address_instr,
  output logic [IW-1:0]   instruction_out
);

  typedef enum logic [2:0] {
    S_LOAD  = 3'd0,
    S_CHECK = 3'd1,
    S_FILL  = 3'd2,
    S_RUN   = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  localparam logic [P-1:0] LAST_ADDR = {P{1'b1}};

  state_t        state, state_nxt;
  logic [IW-1:0] mem [2**P];
  logic [P-1:0]  ptr;
  logic [IW-1:0] instr_q;
  logic          accept;
  logic          prog_end;
  logic          mem_we;
  logic [IW-1:0] mem_wdata;
  logic          restart;

  assign accept   = load.load_valid && load.load_ready;
  // The program ends on an explicit last word or when the top address fills.
  assign prog_end = accept && (load.load_last || (ptr == LAST_ADDR));
  assign restart  = (state != S_LOAD) && (state_nxt == S_LOAD);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam logic [P:0] FULL = {1'b1, {P{1'b0}}};
  logic [IW-1:0] csum;
  logic          load_error_q;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_LOAD;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_LOAD: begin
        if (prog_end) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_nxt = S_CHECK;
`else
          state_nxt = (ptr == LAST_ADDR) ? S_RUN : S_FILL;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (accept) begin
          if (load.load_data != csum)  state_nxt = S_ERROR;
          else if (word_count == FULL) state_nxt = S_RUN;
          else                         state_nxt = S_FILL;
        end
      end
      S_ERROR: if (reload) state_nxt = S_LOAD;
`endif
      S_FILL:  if (ptr == LAST_ADDR) state_nxt = S_RUN;
      S_RUN:   if (reload) state_nxt = S_LOAD;
      default: state_nxt = S_LOAD;
    endcase
  end

  // Output / write-port decode
  always_comb begin
    load.load_ready = 1'b0;
    mem_we          = 1'b0;
    mem_wdata       = load.load_data;
    case (state)
      S_LOAD: begin
        load.load_ready = 1'b1;
        mem_we          = load.load_valid;
      end
      S_CHECK: load.load_ready = 1'b1;
      S_FILL: begin
        mem_we    = 1'b1;
        mem_wdata = FILL;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[ptr] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr        <= '0;
      word_count <= '0;
      cpu_rst_n  <= 1'b0;
      loaded     <= 1'b0;
      instr_q    <= '0;
    end else begin
      // Registered so both rise on the edge entering RUN and fall on the
      // edge that samples reload.
      cpu_rst_n <= (state_nxt == S_RUN);
      loaded    <= (state_nxt == S_RUN);
      if (restart) begin
        ptr        <= '0;
        word_count <= '0;
      end else if (mem_we) begin
        ptr <= ptr + P'(1);
        if (state == S_LOAD) word_count <= word_count + (P+1)'(1);
      end
      // Cleared outside RUN so a stale fetch never reappears after reload.
      if (state != S_RUN)     instr_q <= '0;
      else if (en_read_instr) instr_q <= mem[read_address_instr];
    end
  end

  assign instruction_out = (state == S_RUN) ? instr_q : '0;

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum         <= '0;
      load_error_q <= 1'b0;
    end else begin
      load_error_q <= (state_nxt == S_ERROR);
      if (restart)                       csum <= '0;
      else if (state == S_LOAD && accept) csum <= csum ^ load.load_data;
    end
  end
  assign load_error = load_error_q;
`else
  assign load_error = 1'b0;
`endif

endmodule

// File: doc/imem_loader.md
# imem_loader

Instruction-memory block with a program-load front end, sitting directly upstream of the control FSM. It holds the 2^P-word instruction store and accepts a program over a valid/ready word stream. It fills the unused locations and then releases the FSM from reset. In RUN it serves the FSM's fetch port with a one-cycle registered read, so `instruction_out` is valid during the FSM's decode state.

## Interface
- `M`, default 4: register-address width; instruction width IW = 4+2*M.
- `P`, default 6: instruction-address width; depth 2^P words.
- `FILL`, default 0 (IW bits): value written to every location not loaded.
- `clk`, input, 1 bit: clock.
- `rst_n`, input, 1 bit: reset, asynchronous, active-low.
- `load_valid`, input, 1 bit: load word present.
- `load_ready`, output, 1 bit: block accepts a load word this cycle.
- `load_data`, input, IW bits: load word.
- `load_last`, input, 1 bit: qualifies the final program word.
- `reload`, input, 1 bit: synchronous request to restart loading.
- `cpu_rst_n`, output, 1 bit: active-low reset to the FSM and the datapath.
- `loaded`, output, 1 bit: high while in RUN.
- `load_error`, output, 1 bit: checksum failure; tied 0 without the macro.
- `word_count`, output, P+1 bits: number of program words written.
- `en_read_instr`, input, 1 bit: fetch strobe from the FSM.
- `read_address_instr`, input, P bits: fetch address.
- `instruction_out`, output, IW bits: fetched instruction, feeds the FSM's `instruction_in`.

## Operation
- States: LOAD, CHECK (macro only), FILL, RUN, ERROR (macro only).
- Reset values:
  - State LOAD; write pointer 0.
  - `word_count` 0, `cpu_rst_n` 0, `loaded` 0, `load_error` 0, `instruction_out` 0.
  - Memory array not reset.
- LOAD:
  - `load_ready`=1.
  - On valid&&ready, write `load_data` to mem[ptr], then ptr++ and `word_count`++.
  - Exit when the accepted word has `load_last`=1, or when the word at address 2^P-1 is accepted.
  - Exit target is CHECK with the macro, FILL without it.
- Full buffer: after 2^P words, `load_ready` drops and further words are not accepted. Any later `load_last` is irrelevant.
- FILL:
  - `load_ready`=0.
  - Writes `FILL` to mem[ptr] and increments ptr, one location per cycle, until address 2^P-1 is written; then goes to RUN.
  - If `word_count` = 2^P, FILL is skipped and the block goes straight to RUN.
- RUN:
  - `cpu_rst_n`=1, `loaded`=1, `load_ready`=0.
  - Reads: if `en_read_instr`=1, `instruction_out` <= mem[`read_address_instr`] at the clock edge; otherwise it holds.
- Outside RUN, `instruction_out` is forced to 0 (the ADD-r0 encoding is harmless because the FSM is held in reset).
- Reload:
  - `reload`=1 in RUN or ERROR: next state LOAD, ptr and `word_count` return to 0, `cpu_rst_n` goes 0, `load_error` clears.
  - `reload` in LOAD, CHECK or FILL is ignored.
- Reset mid-load or mid-fill: returns to LOAD with `word_count` 0. Partial contents are overwritten by the next load.
- `word_count` holds its final value through FILL and RUN until reload or reset.

## Timing
- Load handshake:
  - A word is transferred on a posedge with `load_valid`&&`load_ready`; the write happens at the same edge.
  - `load_ready` is a combinational decode of state (1 only in LOAD and CHECK). It never depends on `load_valid`.
  - `load_valid` may drop between words; the block imposes no gap requirement.
- FILL lasts 2^P − `word_count` cycles.
- `cpu_rst_n` and `loaded` are registered:
  - Both rise at the same edge that enters RUN.
  - Both fall at the edge following a `reload` sample.
- Fetch latency is 1 cycle: address sampled at the edge ending the FSM's fetch cycle, data stable for the whole decode cycle.
- Reads never collide with writes, since writes occur only outside RUN.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - The CHECK state is present. After the last program word, exactly one further word is accepted in CHECK as a checksum; it is not written to memory.
  - If the checksum equals the XOR of all program words, go to FILL.
  - Otherwise go to ERROR: `load_error`=1, `cpu_rst_n`=0, `load_ready`=0. Exit only via `reload` or `rst_n`.
- `IMEM_LOADER_CHECKSUM_EN` not defined:
  - There is no CHECK or ERROR state and no checksum word.
  - `load_error` is constantly 0.

## Test plan
- P=6, load 3 words 0x123, 0x456, 0x789 with last on the 3rd → `word_count`=3, 61 FILL cycles, `cpu_rst_n` rises. Fetches of addresses 0/1/2/3 return 0x123/0x456/0x789/0x000, each one cycle after `en_read_instr`.
- Stream 64 words with `load_last`=0 → `load_ready` falls after the 64th word, no FILL cycles, RUN on the next edge, address 63 reads word 64.
- Random 0–5 cycle gaps on `load_valid` during a 10-word load → contents identical to the gap-free load, no word lost or duplicated.
- In RUN, pulse `reload`, load 1 word 0xFFF → `cpu_rst_n` goes 0 the next cycle; after 63 FILL cycles, address 0 reads 0xFFF and address 1 reads `FILL`.
- Assert `rst_n`=0 after 2 of 5 words → all outputs at reset values, `word_count`=0. A reload of 5 words works normally.
- Macro on: words 0x001, 0x002, then checksum 0x003 → RUN. Repeat with checksum 0x004 → ERROR, `load_error`=1, `cpu_rst_n` stays 0 until `reload`.
